// File: rtl/compute_ram_pkg.sv
// Shared encodings, FSM states and elaboration helpers for the compute-RAM engine.
package compute_ram_pkg;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_MUL  = 2'b01;
    localparam logic [1:0] MODE_MAC  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    // Read issue -> write issue: BRAM, lane input register, lane output register.
    localparam int PIPE_LAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic bit lanes_fit(input int dwidth, input int lanes, input int cwidth);
        return (2 * lanes * cwidth) <= dwidth;
    endfunction

endpackage

// File: rtl/compute_lane.sv
// One compute lane: operand register, add/mul/mac select, result register.
// Two register stages, no stall; the accumulator is cleared at job start.
module compute_lane
    import compute_ram_pkg::*;
#(
    parameter int CWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clr,
    input  logic                  i_ld,
    input  logic [CWIDTH-1:0]     i_a,
    input  logic [CWIDTH-1:0]     i_b,
    input  logic                  i_calc,
    input  logic [1:0]            i_mode,
    output logic [2*CWIDTH-1:0]   o_res
);

    logic [CWIDTH-1:0]   r_a;
    logic [CWIDTH-1:0]   r_b;
    logic [2*CWIDTH-1:0] r_acc;
    logic [2*CWIDTH-1:0] r_res;
    logic [2*CWIDTH-1:0] w_a_ext;
    logic [2*CWIDTH-1:0] w_b_ext;
    logic [2*CWIDTH-1:0] w_prod;
    logic [2*CWIDTH-1:0] w_mac;
    logic [2*CWIDTH-1:0] w_res;

    assign w_a_ext = {{CWIDTH{1'b0}}, r_a};
    assign w_b_ext = {{CWIDTH{1'b0}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_mac   = r_acc + w_prod;

    always_comb begin
        w_res = w_mac;
        case (i_mode)
            MODE_ADD: w_res = w_a_ext + w_b_ext;
            MODE_MUL: w_res = w_prod;
            default:  w_res = w_mac;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_res <= '0;
        end else begin
            if (i_ld) begin
                r_a <= i_a;
                r_b <= i_b;
            end
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_calc && (i_mode == MODE_MAC)) begin
                r_acc <= w_mac;
            end
            if (i_calc) begin
                r_res <= w_res;
            end
        end
    end

    assign o_res = r_res;

endmodule

// File: rtl/compute_ram_engine.sv
// Streaming BRAM compute engine: reads packed operands, runs LANES lanes, writes packed results.
// Fixed 3-cycle read-to-write latency at one element per cycle; no stall path, abort flushes.
module compute_ram_engine
    import compute_ram_pkg::*;
#(
    parameter int DWIDTH = 40,
    parameter int AWIDTH = 9,
    parameter int CWIDTH = 8,
    parameter int LANES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [AWIDTH:0]   len,
    input  logic [AWIDTH-1:0] src_base,
    input  logic [AWIDTH-1:0] dst_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [AWIDTH-1:0] rd_addr,
    input  logic [DWIDTH-1:0] rd_data,
    output logic              wr_en,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [DWIDTH-1:0] wr_data
);

    if (!lanes_fit(DWIDTH, LANES, CWIDTH)) begin : g_bad_width
        $error("compute_ram_engine: 2*LANES*CWIDTH exceeds DWIDTH");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_mode;
    logic [AWIDTH:0]     r_left;
    logic [AWIDTH-1:0]   r_rd_addr;
    logic [AWIDTH-1:0]   r_wr_addr;
    logic [PIPE_LAT-1:0] r_vld;
    logic                r_err;
    logic                w_accept;
    logic                w_rd_en;
    logic                w_unused;
    logic [2*CWIDTH-1:0] w_lane_res [LANES];

    assign w_accept = (r_state == ST_IDLE) && start && !abort;
    assign w_rd_en  = (r_state == ST_RUN);
    assign w_unused = ^rd_data;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (mode != MODE_RSVD)) begin
                    w_state_nxt = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_left == (AWIDTH+1)'(1)) w_state_nxt = ST_DRAIN;
            end
            // Leave once only the output stage can still hold a write.
            ST_DRAIN: begin
                if (r_vld[PIPE_LAT-2:0] == '0) w_state_nxt = ST_DONE;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_mode    <= MODE_ADD;
            r_left    <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_vld     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_accept && (mode == MODE_RSVD);
            r_vld   <= abort ? '0 : {r_vld[PIPE_LAT-2:0], w_rd_en};
            if (w_accept) begin
                r_mode    <= mode;
                r_left    <= len;
                r_rd_addr <= src_base;
                r_wr_addr <= dst_base;
            end else begin
                if (w_rd_en) begin
                    r_rd_addr <= r_rd_addr + AWIDTH'(1);
                    r_left    <= r_left - (AWIDTH+1)'(1);
                end
                if (r_vld[PIPE_LAT-1]) begin
                    r_wr_addr <= r_wr_addr + AWIDTH'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        compute_lane #(
            .CWIDTH (CWIDTH)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .i_clr  (w_accept),
            .i_ld   (r_vld[0]),
            .i_a    (rd_data[2*gi*CWIDTH +: CWIDTH]),
            .i_b    (rd_data[(2*gi+1)*CWIDTH +: CWIDTH]),
            .i_calc (r_vld[1]),
            .i_mode (r_mode),
            .o_res  (w_lane_res[gi])
        );
    end

    always_comb begin
        wr_data = '0;
        for (int i = 0; i < LANES; i++) begin
            wr_data[i*2*CWIDTH +: 2*CWIDTH] = w_lane_res[i];
        end
    end

    assign busy    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done    = (r_state == ST_DONE);
    assign err     = r_err;
    assign rd_en   = w_rd_en;
    assign rd_addr = r_rd_addr;
    assign wr_en   = r_vld[PIPE_LAT-1];
    assign wr_addr = r_wr_addr;

endmodule
